// File: rtl/ofdm_pkg.sv
// Shared OFDM constants: preamble lengths, FSM encoding and the pre-scaled
// 802.11a short/long training sequences (same scaling as the RX correlator).
package ofdm_pkg;

    localparam int DW        = 32;
    localparam int SHORT_LEN = 160;
    localparam int LONG_LEN  = 160;
    localparam int PRE_LEN   = SHORT_LEN + LONG_LEN;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHORT = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    // Packs a complex sample given in units of 1e-3; 1.0 maps to 16000.
    function automatic logic [DW-1:0] cs(input int re_m, input int im_m);
        logic [15:0] re_q;
        logic [15:0] im_q;
        re_q = 16'(re_m * 16);
        im_q = 16'(im_m * 16);
        return {re_q, im_q};
    endfunction

    localparam logic [DW-1:0] SHORT_SEQ [16] = '{
        cs(  46,   46), cs(-132,    2), cs( -13,  -79), cs( 143,  -13),
        cs(  92,    0), cs( 143,  -13), cs( -13,  -79), cs(-132,    2),
        cs(  46,   46), cs(   2, -132), cs( -79,  -13), cs( -13,  143),
        cs(   0,   92), cs( -13,  143), cs( -79,  -13), cs(   2, -132)
    };

    localparam logic [DW-1:0] LONG_SEQ [64] = '{
        cs( 156,    0), cs(  -5, -120), cs(  40, -111), cs(  97,   83),
        cs(  21,   28), cs(  60,  -88), cs(-115,  -55), cs( -38, -106),
        cs(  98,  -26), cs(  53,    4), cs(   1, -115), cs(-137,  -47),
        cs(  24,  -59), cs(  59,  -15), cs( -22,  161), cs( 119,   -4),
        cs(  62,  -62), cs(  37,   98), cs( -57,   39), cs(-131,   65),
        cs(  82,   92), cs(  70,   14), cs( -60,   81), cs( -56,  -22),
        cs( -35, -151), cs(-122,  -17), cs(-127,  -21), cs(  75,  -74),
        cs(  -3,   54), cs( -92,  115), cs(  92,  106), cs(  12,   98),
        cs(-156,    0), cs(  12,  -98), cs(  92, -106), cs( -92, -115),
        cs(  -3,  -54), cs(  75,   74), cs(-127,   21), cs(-122,   17),
        cs( -35,  151), cs( -56,   22), cs( -60,  -81), cs(  70,  -14),
        cs(  82,  -92), cs(-131,  -65), cs( -57,  -39), cs(  37,  -98),
        cs(  62,   62), cs( 119,    4), cs( -22, -161), cs(  59,   15),
        cs(  24,   59), cs(-137,   47), cs(   1,  115), cs(  53,   -4),
        cs(  98,   26), cs( -38,  106), cs(-115,   55), cs(  60,   88),
        cs(  21,  -28), cs(  97,  -83), cs(  40,  111), cs(  -5,  120)
    };

endpackage

// File: rtl/preamble_insert_if.sv
// Streaming bus around preamble_insert: upstream (cyc_i/stb_i/dat_in/ack_o)
// and downstream (dat_out/cyc_o/stb_o/we_o/ack_i) in one bundle.
interface preamble_insert_if;
    import ofdm_pkg::*;

    logic          cyc_i;
    logic          stb_i;
    logic [DW-1:0] dat_in;
    logic          ack_o;
    logic [DW-1:0] dat_out;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic          ack_i;

    modport slave (
        input  cyc_i, stb_i, dat_in, ack_i,
        output ack_o, dat_out, cyc_o, stb_o, we_o
    );

    modport master (
        output cyc_i, stb_i, dat_in, ack_i,
        input  ack_o, dat_out, cyc_o, stb_o, we_o
    );

endinterface

// File: rtl/preamble_insert_rom.sv
// Preamble sample ROM: addr[6] selects the long sequence, otherwise the
// short sequence indexed by addr[3:0].
module preamble_rom
    import ofdm_pkg::*;
(
    input  logic [6:0]    addr,
    output logic [DW-1:0] dat
);

    logic unused_addr;
    assign unused_addr = ^addr[5:4];

    // Combinational table lookup.
    always_comb begin
        if (addr[6]) begin
            dat = LONG_SEQ[addr[5:0]];
        end else begin
            dat = SHORT_SEQ[addr[3:0]];
        end
    end

endmodule

// File: rtl/preamble_insert.sv
// Prefixes each outgoing frame with the 802.11a short + long preamble and
// then forwards upstream samples unchanged, honouring downstream stalls.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | no frame; waiting for a rising edge on cyc_i
//  ST_SHORT | emitting short preamble, cnt 0..159
//  ST_LONG  | emitting long preamble (GI2 + 2 symbols), cnt 160..319
//  ST_DATA  | forwarding upstream samples until cyc_i drops and out is empty
module preamble_insert
    import ofdm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    preamble_insert_if.slave   bus
);

    logic [1:0]    state;
    logic [8:0]    cnt;
    logic [8:0]    cnt_nxt;
    logic          cyc_i_pp;
    logic [DW-1:0] dat_out_r;
    logic          cyc_o_r;
    logic          stb_o_r;

    logic          out_halt;
    logic          out_take;
    logic          frame_start;
    logic          ack_o_int;
    logic [6:0]    rom_addr;
    logic [DW-1:0] rom_dat;

    assign out_halt    = stb_o_r & ~bus.ack_i;
    assign out_take    = stb_o_r & bus.ack_i;
    assign frame_start = (state == ST_IDLE) & bus.cyc_i & ~cyc_i_pp;
    assign ack_o_int   = (state == ST_DATA) & bus.cyc_i & bus.stb_i & ~out_halt;

    // Index of the preamble sample to load next: 0 from IDLE, else cnt+1.
    always_comb begin
        cnt_nxt = 9'd0;
        if (state != ST_IDLE && cnt != 9'(PRE_LEN - 1)) begin
            cnt_nxt = cnt + 9'd1;
        end
    end

    // The ROM is addressed one sample ahead because dat_out is registered.
    assign rom_addr = {(cnt_nxt >= 9'(SHORT_LEN)), cnt_nxt[5:0]};

    preamble_rom u_rom (
        .addr (rom_addr),
        .dat  (rom_dat)
    );

    // Frame sequencing and output registers; nothing moves while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 9'd0;
            cyc_i_pp  <= 1'b0;
            dat_out_r <= '0;
            cyc_o_r   <= 1'b0;
            stb_o_r   <= 1'b0;
        end else begin
            cyc_i_pp <= bus.cyc_i;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state     <= ST_SHORT;
                        cnt       <= 9'd0;
                        cyc_o_r   <= 1'b1;
                        stb_o_r   <= 1'b1;
                        dat_out_r <= rom_dat;
                    end
                end
                ST_SHORT, ST_LONG: begin
                    if (out_take) begin
                        cnt <= cnt_nxt;
                        if (cnt == 9'(PRE_LEN - 1)) begin
                            state   <= ST_DATA;
                            stb_o_r <= 1'b0;
                        end else begin
                            dat_out_r <= rom_dat;
                            if (cnt == 9'(SHORT_LEN - 1)) begin
                                state <= ST_LONG;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (!out_halt) begin
                        if (ack_o_int) begin
                            dat_out_r <= bus.dat_in;
                            stb_o_r   <= 1'b1;
                        end else begin
                            stb_o_r <= 1'b0;
                            if (!bus.cyc_i && !stb_o_r) begin
                                cyc_o_r <= 1'b0;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o   = ack_o_int;
    assign bus.dat_out = dat_out_r;
    assign bus.cyc_o   = cyc_o_r;
    assign bus.stb_o   = stb_o_r;
    assign bus.we_o    = stb_o_r;

endmodule

// File: tb/tb_preamble_insert.sv
// Scoreboard bench for preamble_insert: stimulus pushes expected output
// samples; a negedge monitor pops and compares on every accepted transfer.
module tb_preamble_insert;
    import ofdm_pkg::*;

    logic clk = 1'b0;
    logic rst;

    preamble_insert_if bus();

    preamble_insert dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q [$];
    int            out_idx  = 0;
    int            n_acc    = 0;
    logic [DW-1:0] cap [0:399];
    bit            ack_pre_seen = 1'b0;
    bit            ack_seen     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted output sample against the scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst) begin
            if (!bus.cyc_o) out_idx = 0;
            if (bus.ack_o) ack_seen = 1'b1;
            if (bus.ack_o && out_idx < PRE_LEN) ack_pre_seen = 1'b1;
            if (bus.stb_o && bus.ack_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sample_unexpected idx=%0d got %h expected none", out_idx, bus.dat_out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sample[%0d]", out_idx), 64'(bus.dat_out), 64'(e));
                end
                check("we_o", 64'(bus.we_o), 64'(bus.stb_o));
                if (out_idx < 400) cap[out_idx] = bus.dat_out;
                out_idx++;
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pre();
        for (int i = 0; i < PRE_LEN; i++) begin
            if (i < SHORT_LEN) exp_q.push_back(SHORT_SEQ[i % 16]);
            else               exp_q.push_back(LONG_SEQ[i % 64]);
        end
    endtask

    task automatic start_frame(input string tag);
        n_acc = 0;
        push_pre();
        bus.cyc_i = 1'b1;
        tick();
        check({tag, "_lat_cyc_o"}, 64'(bus.cyc_o), 64'd1);
        check({tag, "_lat_stb_o"}, 64'(bus.stb_o), 64'd1);
        check({tag, "_lat_dat"}, 64'(bus.dat_out), 64'(SHORT_SEQ[0]));
    endtask

    task automatic wait_idx(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            tick();
            if (out_idx == n) hit = 1'b1;
        end
        check($sformatf("wait_idx_%0d", n), 64'(hit), 64'd1);
    endtask

    task automatic wait_idle();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (!bus.cyc_o) hit = 1'b1;
            else tick();
        end
        check("wait_idle", 64'(hit), 64'd1);
    endtask

    task automatic up_send(input logic [DW-1:0] v);
        bit got;
        got = 1'b0;
        bus.stb_i  = 1'b1;
        bus.dat_in = v;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            if (bus.ack_o) got = 1'b1;
        end
        check("up_send_ack", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        bus.stb_i = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(base + DW'(k));
            up_send(base + DW'(k));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.cyc_i  = 1'b0;
        bus.stb_i  = 1'b0;
        bus.dat_in = '0;
        bus.ack_i  = 1'b1;
        repeat (3) tick();
        check("rst_dat_out", 64'(bus.dat_out), 64'd0);
        check("rst_cyc_o", 64'(bus.cyc_o), 64'd0);
        check("rst_stb_o", 64'(bus.stb_o), 64'd0);
        check("rst_ack_o", 64'(bus.ack_o), 64'd0);
        rst = 1'b0;
        tick();

        // Full frame with 80 data samples; upstream offers data from the start.
        ack_pre_seen = 1'b0;
        start_frame("t1");
        send_data(32'hD000_0000, 80);
        bus.cyc_i = 1'b0;
        tick();
        check("t4_stb_o_after_last", 64'(bus.stb_o), 64'd0);
        check("t4_cyc_o_held", 64'(bus.cyc_o), 64'd1);
        tick();
        check("t4_cyc_o_fall", 64'(bus.cyc_o), 64'd0);
        check("t1_strobes", 64'(n_acc), 64'd400);
        check("t1_s0", 64'(cap[0]), 64'(SHORT_SEQ[0]));
        check("t1_s15", 64'(cap[15]), 64'(SHORT_SEQ[15]));
        check("t1_s16", 64'(cap[16]), 64'(SHORT_SEQ[0]));
        check("t1_s160", 64'(cap[160]), 64'(LONG_SEQ[32]));
        check("t1_s191", 64'(cap[191]), 64'(LONG_SEQ[63]));
        check("t1_s192", 64'(cap[192]), 64'(LONG_SEQ[0]));
        check("t1_s319", 64'(cap[319]), 64'(LONG_SEQ[63]));
        check("t1_s320", 64'(cap[320]), 64'h0000_0000_D000_0000);
        check("t1_s399", 64'(cap[399]), 64'h0000_0000_D000_004F);
        check("t1_no_ack_in_pre", 64'(ack_pre_seen), 64'd0);
        tick();

        // Restart, backpressure at cnt=100, then a 3-cycle upstream gap.
        start_frame("t4_restart");
        wait_idx(100);
        bus.ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_dat", 64'(bus.dat_out), 64'(SHORT_SEQ[4]));
            check("t2_hold_stb", 64'(bus.stb_o), 64'd1);
        end
        bus.ack_i = 1'b1;
        send_data(32'hE000_0000, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_gap_stb_o", 64'(bus.stb_o), 64'd0);
            check("t3_gap_cyc_o", 64'(bus.cyc_o), 64'd1);
            check("t3_gap_ack_o", 64'(bus.ack_o), 64'd0);
        end
        send_data(32'hE000_0004, 4);
        bus.cyc_i = 1'b0;
        wait_idle();
        check("t3_strobes", 64'(n_acc), 64'd328);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset mid-preamble at cnt=200, then a clean frame.
        start_frame("t5_pre");
        wait_idx(200);
        rst       = 1'b1;
        bus.cyc_i = 1'b0;
        tick();
        check("t5_cyc_o", 64'(bus.cyc_o), 64'd0);
        check("t5_stb_o", 64'(bus.stb_o), 64'd0);
        check("t5_dat_out", 64'(bus.dat_out), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        start_frame("t5_post");
        send_data(32'hA000_0000, 2);
        bus.cyc_i = 1'b0;
        wait_idle();
        check("t5_strobes", 64'(n_acc), 64'd322);
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // cyc_i dropped at cnt=50 (and a stray re-rise mid-preamble).
        ack_seen = 1'b0;
        start_frame("t6");
        bus.stb_i  = 1'b1;
        bus.dat_in = 32'hBAD0_0000;
        wait_idx(50);
        bus.cyc_i = 1'b0;
        wait_idx(60);
        bus.cyc_i = 1'b1;
        wait_idx(70);
        bus.cyc_i = 1'b0;
        wait_idle();
        check("t6_strobes", 64'(n_acc), 64'd320);
        check("t6_ack_o_never", 64'(ack_seen), 64'd0);
        check("t6_q_empty", 64'(exp_q.size()), 64'd0);
        bus.stb_i = 1'b0;
        tick();
        check("end_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
